// File: rtl/adc_chan_avg_if.sv
// Bundles the ADC sample stream, the averaged result stream and the CSR bus of adc_chan_avg.
// The master side drives samples and CSR strobes; the slave side is the averager.
interface adc_chan_avg_if;
    logic        in_valid;
    logic [4:0]  in_channel;
    logic [11:0] in_data;
    logic        out_valid;
    logic [4:0]  out_channel;
    logic [11:0] out_data;
    logic [4:0]  csr_address;
    logic        csr_read;
    logic        csr_write;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata;

    modport master (
        output in_valid, in_channel, in_data,
        output csr_address, csr_read, csr_write, csr_writedata,
        input  out_valid, out_channel, out_data, csr_readdata
    );

    modport slave (
        input  in_valid, in_channel, in_data,
        input  csr_address, csr_read, csr_write, csr_writedata,
        output out_valid, out_channel, out_data, csr_readdata
    );
endinterface

// File: rtl/adc_chan_avg.sv
// Per-channel block averager for ADC response samples: accumulates 2^AVG_LOG2 samples per channel,
// emits the truncated mean as a one-cycle pulse and keeps the latest mean readable over the CSR bus.
module adc_chan_avg #(
    parameter int AVG_LOG2 = 4,
    parameter int NUM_CH   = 16
) (
    input logic           clk_clk,
    input logic           reset_reset,
    adc_chan_avg_if.slave bus
);
    localparam int AW = 12 + AVG_LOG2;
    localparam int CW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam logic [CW-1:0] CNT_LAST  = CW'((1 << AVG_LOG2) - 1);
    localparam logic [4:0]    ADDR_DROP = 5'd16;
    localparam logic [4:0]    ADDR_CTRL = 5'd17;

    // Storage is sized for the full 16-channel address space so a 4-bit index is always legal;
    // entries at or above NUM_CH are never written and stay at zero.
    logic [AW-1:0] acc_q [16];
    logic [AW-1:0] acc_d [16];
    logic [CW-1:0] cnt_q [16];
    logic [CW-1:0] cnt_d [16];
    logic [11:0]   avg_q [16];
    logic [11:0]   avg_d [16];
    logic [15:0]   fresh_q, fresh_d;
    logic [15:0]   drop_q, drop_d;
    logic          enable_q, enable_d;
    logic          out_valid_q, out_valid_d;
    logic [4:0]    out_channel_q, out_channel_d;
    logic [11:0]   out_data_q, out_data_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [3:0]    in_ch;
    logic [3:0]    rd_ch;
    logic          in_range;
    logic          accept;
    logic          drop;
    logic          complete;
    logic          ctrl_wr;
    logic          clear;
    logic          rd_chan;
    logic [AW-1:0] sum;

    wire unused_wdata = ^bus.csr_writedata[31:2];

    always_comb begin
        in_ch    = bus.in_channel[3:0];
        rd_ch    = bus.csr_address[3:0];
        in_range = bus.in_channel < 5'(NUM_CH);
        accept   = enable_q && bus.in_valid && in_range;
        drop     = enable_q && bus.in_valid && !in_range;
        sum      = acc_q[in_ch] + AW'(bus.in_data);
        complete = accept && (cnt_q[in_ch] == CNT_LAST);
        ctrl_wr  = bus.csr_write && (bus.csr_address == ADDR_CTRL);
        clear    = ctrl_wr && bus.csr_writedata[1];
        rd_chan  = bus.csr_read && (bus.csr_address < 5'(NUM_CH));
    end

    // Priority: read-clear of fresh, then completion, then the CSR clear overrides everything.
    always_comb begin
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        avg_d         = avg_q;
        fresh_d       = fresh_q;
        drop_d        = drop_q;
        enable_d      = enable_q;
        out_valid_d   = 1'b0;
        out_channel_d = out_channel_q;
        out_data_d    = out_data_q;
        rdata_d       = rdata_q;

        if (rd_chan) begin
            fresh_d[rd_ch] = 1'b0;
        end

        if (accept) begin
            if (complete) begin
                acc_d[in_ch]   = '0;
                cnt_d[in_ch]   = '0;
                avg_d[in_ch]   = 12'(sum >> AVG_LOG2);
                fresh_d[in_ch] = 1'b1;
                out_valid_d    = 1'b1;
                out_channel_d  = bus.in_channel;
                out_data_d     = 12'(sum >> AVG_LOG2);
            end else begin
                acc_d[in_ch] = sum;
                cnt_d[in_ch] = cnt_q[in_ch] + CW'(1);
            end
        end

        if (drop && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end

        if (ctrl_wr) begin
            enable_d = bus.csr_writedata[0];
        end

        if (clear) begin
            for (int i = 0; i < 16; i++) begin
                acc_d[i] = '0;
                cnt_d[i] = '0;
                avg_d[i] = '0;
            end
            fresh_d     = '0;
            drop_d      = '0;
            out_valid_d = 1'b0;
        end

        if (bus.csr_read) begin
            if (rd_chan) begin
                rdata_d = {fresh_q[rd_ch], 19'b0, avg_q[rd_ch]};
            end else if (bus.csr_address == ADDR_DROP) begin
                rdata_d = {16'b0, drop_q};
            end else if (bus.csr_address == ADDR_CTRL) begin
                rdata_d = {31'b0, enable_q};
            end else begin
                rdata_d = '0;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < 16; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
                avg_q[i] <= '0;
            end
            fresh_q       <= '0;
            drop_q        <= '0;
            enable_q      <= 1'b1;
            out_valid_q   <= 1'b0;
            out_channel_q <= '0;
            out_data_q    <= '0;
            rdata_q       <= '0;
        end else begin
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            avg_q         <= avg_d;
            fresh_q       <= fresh_d;
            drop_q        <= drop_d;
            enable_q      <= enable_d;
            out_valid_q   <= out_valid_d;
            out_channel_q <= out_channel_d;
            out_data_q    <= out_data_d;
            rdata_q       <= rdata_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_channel  = out_channel_q;
    assign bus.out_data     = out_data_q;
    assign bus.csr_readdata = rdata_q;
endmodule

// File: tb/tb_adc_chan_avg.sv
// Directed bench for adc_chan_avg with default parameters (16-sample windows, 16 channels).
module tb_adc_chan_avg;
    logic clk_clk = 1'b0;
    logic reset_reset;

    adc_chan_avg_if bus ();

    adc_chan_avg #(.AVG_LOG2(4), .NUM_CH(16)) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .bus         (bus)
    );

    always #5 clk_clk = ~clk_clk;

    int          n_chk = 0;
    int          n_bad = 0;
    int          n_out = 0;
    int          res_cnt [32] = '{default: 0};
    logic [11:0] res_data [32] = '{default: '0};

    // Each out_valid pulse spans exactly one negedge.
    always @(negedge clk_clk) begin
        if (bus.out_valid) begin
            n_out++;
            res_cnt[bus.out_channel]++;
            res_data[bus.out_channel] = bus.out_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic send(input logic [4:0] ch, input logic [11:0] d);
        bus.in_valid   = 1'b1;
        bus.in_channel = ch;
        bus.in_data    = d;
        tick();
        bus.in_valid   = 1'b0;
    endtask

    task automatic csr_rd(input logic [4:0] a, output logic [31:0] d);
        bus.csr_read    = 1'b1;
        bus.csr_address = a;
        tick();
        bus.csr_read    = 1'b0;
        d = bus.csr_readdata;
    endtask

    task automatic csr_wr(input logic [4:0] a, input logic [31:0] d);
        bus.csr_write     = 1'b1;
        bus.csr_address   = a;
        bus.csr_writedata = d;
        tick();
        bus.csr_write     = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          base;
        int          base2;

        bus.in_valid      = 1'b0;
        bus.in_channel    = '0;
        bus.in_data       = '0;
        bus.csr_address   = '0;
        bus.csr_read      = 1'b0;
        bus.csr_write     = 1'b0;
        bus.csr_writedata = '0;
        reset_reset       = 1'b1;
        repeat (3) @(posedge clk_clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_channel", 32'(bus.out_channel), 32'd0);
        chk("rst_readdata", bus.csr_readdata, 32'd0);
        reset_reset = 1'b0;
        csr_rd(5'd17, rd);
        chk("rst_enable", rd, 32'd1);

        // 100..115 on ch3: sum 1720, mean 107
        base = res_cnt[3];
        for (int i = 0; i < 16; i++) begin
            send(5'd3, 12'(100 + i));
            if (i == 14) chk("ch3_early", 32'(bus.out_valid), 32'd0);
        end
        chk("ch3_lat_valid", 32'(bus.out_valid), 32'd1);
        chk("ch3_lat_data", 32'(bus.out_data), 32'd107);
        chk("ch3_lat_chan", 32'(bus.out_channel), 32'd3);
        csr_rd(5'd3, rd);
        chk("ch3_rd_fresh", rd, 32'h8000006B);
        chk("ch3_pulses", 32'(res_cnt[3] - base), 32'd1);
        csr_rd(5'd3, rd);
        chk("ch3_rd_stale", rd, 32'h0000006B);

        // interleaved ch0 full-scale / ch1 zero, completions on consecutive edges
        base  = res_cnt[0];
        base2 = res_cnt[1];
        for (int i = 0; i < 16; i++) begin
            send(5'd0, 12'd4095);
            send(5'd1, 12'd0);
        end
        tick();
        chk("ch0_pulses", 32'(res_cnt[0] - base), 32'd1);
        chk("ch0_data", 32'(res_data[0]), 32'd4095);
        chk("ch1_pulses", 32'(res_cnt[1] - base2), 32'd1);
        chk("ch1_data", 32'(res_data[1]), 32'd0);
        csr_rd(5'd0, rd);
        chk("ch0_rd", rd, 32'h80000FFF);
        csr_rd(5'd1, rd);
        chk("ch1_rd", rd, 32'h80000000);

        // highest channel, truncation: 8*4095/16 = 2047.5 -> 2047
        base = res_cnt[15];
        for (int i = 0; i < 16; i++) send(5'd15, (i % 2 == 0) ? 12'd4095 : 12'd0);
        tick();
        chk("ch15_pulses", 32'(res_cnt[15] - base), 32'd1);
        chk("ch15_data", 32'(res_data[15]), 32'd2047);

        // out-of-range drops and saturation
        base = n_out;
        for (int i = 0; i < 3; i++) send(5'd16, 12'd7);
        csr_rd(5'd16, rd);
        chk("drop_3", rd, 32'd3);
        bus.in_valid   = 1'b1;
        bus.in_channel = 5'd20;
        bus.in_data    = 12'd1;
        repeat (70000) @(posedge clk_clk);
        #1;
        bus.in_valid = 1'b0;
        tick();
        chk("drop_no_out", 32'(n_out - base), 32'd0);
        csr_rd(5'd16, rd);
        chk("drop_sat", rd, 32'h0000FFFF);

        // 8 samples on ch5, clear together with the 9th, then 16 samples of 8
        base = res_cnt[5];
        for (int i = 0; i < 8; i++) send(5'd5, 12'd200);
        bus.in_valid      = 1'b1;
        bus.in_channel    = 5'd5;
        bus.in_data       = 12'd200;
        bus.csr_write     = 1'b1;
        bus.csr_address   = 5'd17;
        bus.csr_writedata = 32'h3;
        tick();
        bus.in_valid  = 1'b0;
        bus.csr_write = 1'b0;
        chk("clr_no_valid", 32'(bus.out_valid), 32'd0);
        csr_rd(5'd16, rd);
        chk("clr_drop", rd, 32'd0);
        csr_rd(5'd0, rd);
        chk("clr_avg0", rd, 32'd0);
        csr_rd(5'd17, rd);
        chk("clr_enable", rd, 32'd1);
        for (int i = 0; i < 16; i++) begin
            send(5'd5, 12'd8);
            if (i == 14) chk("ch5_early", 32'(res_cnt[5] - base), 32'd0);
        end
        tick();
        chk("ch5_pulses", 32'(res_cnt[5] - base), 32'd1);
        chk("ch5_data", 32'(res_data[5]), 32'd8);

        // clear on the same edge as a completing sample suppresses the result
        base = res_cnt[6];
        for (int i = 0; i < 15; i++) send(5'd6, 12'd1);
        bus.in_valid      = 1'b1;
        bus.in_channel    = 5'd6;
        bus.in_data       = 12'd1;
        bus.csr_write     = 1'b1;
        bus.csr_address   = 5'd17;
        bus.csr_writedata = 32'h3;
        tick();
        bus.in_valid  = 1'b0;
        bus.csr_write = 1'b0;
        chk("clr_cmpl_valid", 32'(bus.out_valid), 32'd0);
        csr_rd(5'd6, rd);
        chk("clr_cmpl_rd", rd, 32'd0);
        chk("clr_cmpl_pulses", 32'(res_cnt[6] - base), 32'd0);

        // completion on ch2 on the same edge as a read of addr 2: (15*40+56)/16 = 41
        for (int i = 0; i < 15; i++) send(5'd2, 12'd40);
        bus.in_valid    = 1'b1;
        bus.in_channel  = 5'd2;
        bus.in_data     = 12'd56;
        bus.csr_read    = 1'b1;
        bus.csr_address = 5'd2;
        tick();
        bus.in_valid = 1'b0;
        bus.csr_read = 1'b0;
        chk("ch2_rd_pre", bus.csr_readdata, 32'd0);
        chk("ch2_out_data", 32'(bus.out_data), 32'd41);
        csr_rd(5'd2, rd);
        chk("ch2_rd_fresh", rd, 32'h80000029);
        csr_rd(5'd2, rd);
        chk("ch2_rd_stale", rd, 32'h00000029);

        // reset mid-window discards the partial sum
        base = res_cnt[7];
        for (int i = 0; i < 10; i++) send(5'd7, 12'd999);
        reset_reset = 1'b1;
        tick();
        reset_reset = 1'b0;
        chk("rst2_readdata", bus.csr_readdata, 32'd0);
        csr_rd(5'd2, rd);
        chk("rst2_avg2", rd, 32'd0);
        for (int i = 0; i < 15; i++) send(5'd7, 12'd50);
        tick();
        chk("ch7_early", 32'(res_cnt[7] - base), 32'd0);
        send(5'd7, 12'd50);
        tick();
        chk("ch7_pulses", 32'(res_cnt[7] - base), 32'd1);
        chk("ch7_data", 32'(res_data[7]), 32'd50);

        // disable with simultaneous read, partial sums retained: (8*30+8*10)/16 = 20
        base = res_cnt[9];
        for (int i = 0; i < 8; i++) send(5'd9, 12'd30);
        bus.csr_read      = 1'b1;
        bus.csr_write     = 1'b1;
        bus.csr_address   = 5'd17;
        bus.csr_writedata = 32'h0;
        tick();
        bus.csr_read  = 1'b0;
        bus.csr_write = 1'b0;
        chk("rw_pre", bus.csr_readdata, 32'd1);
        csr_rd(5'd17, rd);
        chk("rw_post", rd, 32'd0);
        for (int i = 0; i < 8; i++) send(5'd9, 12'd1000);
        send(5'd20, 12'd1);
        send(5'd20, 12'd1);
        tick();
        chk("dis_no_out", 32'(res_cnt[9] - base), 32'd0);
        csr_rd(5'd16, rd);
        chk("dis_no_drop", rd, 32'd0);
        csr_wr(5'd17, 32'h1);
        for (int i = 0; i < 8; i++) send(5'd9, 12'd10);
        tick();
        chk("ch9_pulses", 32'(res_cnt[9] - base), 32'd1);
        chk("ch9_data", 32'(res_data[9]), 32'd20);

        // ignored writes, unmapped reads, readdata hold
        csr_wr(5'd3, 32'hFFFFFFFF);
        csr_rd(5'd3, rd);
        chk("wr_ignored", rd, 32'd0);
        csr_rd(5'd18, rd);
        chk("rd_unmapped", rd, 32'd0);
        csr_rd(5'd17, rd);
        tick();
        tick();
        chk("rd_hold", bus.csr_readdata, 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
